// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: shared types and helpers for the load/store issue stage.
// Access sizes, the split FSM states, the load-part tag and the
// byte-count / byte-mask helper functions live here.
package rv_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } t_mem_size;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } t_lsu_state;

  typedef enum logic [1:0] {
    PART_NONE   = 2'd0,
    PART_FIRST  = 2'd1,
    PART_SECOND = 2'd2
  } t_ld_part;

  // Number of bytes touched by an access; encoding 3 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (t_mem_size'(size))
      BYTE:    n = 3'd1;
      HALF:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Low-justified contiguous mask of n bytes.
  function automatic logic [3:0] len_mask(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd0:    m = 4'b0000;
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rv_ld_merge.sv
// rv_ld_merge: Q104H side of the load/store issue stage.
// Tracks what was issued in Q103H, keeps the first half of a split load
// and merges it with the second half when that returns.
module rv_ld_merge
  import rv_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_valid_Q103H,
  input  logic        is_load_Q103H,
  input  t_ld_part    part_Q103H,
  input  logic [1:0]  n1_Q103H,
  input  logic [31:0] rd_data_Q104H,
  output logic [31:0] ld_data_Q104H,
  output logic        ld_valid_Q104H
);

  logic        tag_valid_r;
  logic        tag_is_load_r;
  t_ld_part    tag_part_r;
  logic [1:0]  tag_n1_r;
  logic [31:0] hold_r;
  logic [4:0]  shift_s;
  logic [31:0] ld_data_s;
  logic        ld_valid_s;

  // Q104H tag: describes the access whose read data arrives this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_r   <= 1'b0;
      tag_is_load_r <= 1'b0;
      tag_part_r    <= PART_NONE;
      tag_n1_r      <= 2'd0;
    end else begin
      tag_valid_r   <= acc_valid_Q103H;
      tag_is_load_r <= is_load_Q103H;
      tag_part_r    <= part_Q103H;
      tag_n1_r      <= n1_Q103H;
    end
  end

  // Hold the low bytes returned by the first half of a split load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= 32'd0;
    end else if (tag_valid_r && tag_is_load_r && (tag_part_r == PART_FIRST)) begin
      hold_r <= rd_data_Q104H;
    end else begin
      hold_r <= hold_r;
    end
  end

  assign shift_s = {tag_n1_r, 3'b000};

  // Produce the load result: pass-through when aligned, merge on second half.
  always_comb begin
    ld_data_s  = 32'd0;
    ld_valid_s = 1'b0;
    if (tag_valid_r && tag_is_load_r) begin
      case (tag_part_r)
        PART_NONE: begin
          ld_data_s  = rd_data_Q104H;
          ld_valid_s = 1'b1;
        end
        PART_FIRST: begin
          ld_data_s  = 32'd0;
          ld_valid_s = 1'b0;
        end
        PART_SECOND: begin
          // Sign extension of the second half already fills the top bits.
          ld_data_s  = (rd_data_Q104H << shift_s) | hold_r;
          ld_valid_s = 1'b1;
        end
        default: begin
          ld_data_s  = 32'd0;
          ld_valid_s = 1'b0;
        end
      endcase
    end else begin
      ld_data_s  = 32'd0;
      ld_valid_s = 1'b0;
    end
  end

  assign ld_data_Q104H  = ld_data_s;
  assign ld_valid_Q104H = ld_valid_s;

endmodule

// File: rtl/rv_lsu_split.sv
// rv_lsu_split: load/store issue stage between execute (Q102H) and the
// data-memory wrapper (Q103H/Q104H). Accesses crossing a word boundary
// are issued as two wrapper accesses while Q102H is stalled.
// Build option: RV_LSU_MISALIGN_EN enables splitting; without it a
// misaligned request is dropped and flagged on misalign_err_Q103H.
module rv_lsu_split
  import rv_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_Q102H,
  input  logic [31:0] req_addr_Q102H,
  input  logic [31:0] req_wr_data_Q102H,
  input  logic        req_is_store_Q102H,
  input  logic [1:0]  req_size_Q102H,
  input  logic        req_is_signed_Q102H,
  output logic        stall_Q102H,
  output logic [31:0] addr_Q103H,
  output logic [31:0] wr_data_Q103H,
  output logic        wr_en_Q103H,
  output logic [3:0]  byte_en_Q103H,
  output logic        is_signed_Q103H,
  input  logic [31:0] rd_data_Q104H,
  output logic [31:0] ld_data_Q104H,
  output logic        ld_valid_Q104H,
  output logic        misalign_err_Q103H
);

  t_lsu_state  state_r, state_nxt_s;
  logic [31:0] addr_r, addr_nxt_s;
  logic [31:0] wr_data_r, wr_data_nxt_s;
  logic        wr_en_r, wr_en_nxt_s;
  logic [3:0]  byte_en_r, byte_en_nxt_s;
  logic        is_signed_r, is_signed_nxt_s;
  t_ld_part    part_r, part_nxt_s;
  logic [1:0]  n1_r, n1_nxt_s;
  logic        err_r, err_nxt_s;

  logic [2:0]  sz_s;
  logic [1:0]  off_s;
  logic [2:0]  end_s;
  logic        misalign_s;

`ifdef RV_LSU_MISALIGN_EN
  logic [2:0]  n1_s;
  logic [2:0]  n2_s;
  logic [31:0] sec_addr_r, sec_addr_nxt_s;
  logic [31:0] sec_wr_data_r, sec_wr_data_nxt_s;
  logic        sec_wr_en_r, sec_wr_en_nxt_s;
  logic [3:0]  sec_byte_en_r, sec_byte_en_nxt_s;
  logic        sec_is_signed_r, sec_is_signed_nxt_s;
`endif

  assign sz_s       = size_bytes(req_size_Q102H);
  assign off_s      = req_addr_Q102H[1:0];
  assign end_s      = {1'b0, off_s} + sz_s;
  assign misalign_s = (end_s > 3'd4);

`ifdef RV_LSU_MISALIGN_EN
  assign n1_s = 3'd4 - {1'b0, off_s};
  assign n2_s = sz_s - n1_s;
`endif

  // Next state and next Q103H contents; idle cycles drop the enables only.
  always_comb begin
    state_nxt_s     = state_r;
    addr_nxt_s      = addr_r;
    wr_data_nxt_s   = wr_data_r;
    wr_en_nxt_s     = 1'b0;
    byte_en_nxt_s   = 4'b0000;
    is_signed_nxt_s = is_signed_r;
    part_nxt_s      = PART_NONE;
    n1_nxt_s        = n1_r;
    err_nxt_s       = 1'b0;
`ifdef RV_LSU_MISALIGN_EN
    sec_addr_nxt_s      = sec_addr_r;
    sec_wr_data_nxt_s   = sec_wr_data_r;
    sec_wr_en_nxt_s     = sec_wr_en_r;
    sec_byte_en_nxt_s   = sec_byte_en_r;
    sec_is_signed_nxt_s = sec_is_signed_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid_Q102H && misalign_s) begin
`ifdef RV_LSU_MISALIGN_EN
          // First half: low bytes up to the word boundary, never sign-extended.
          addr_nxt_s      = req_addr_Q102H;
          wr_data_nxt_s   = req_wr_data_Q102H;
          wr_en_nxt_s     = req_is_store_Q102H;
          byte_en_nxt_s   = len_mask(n1_s);
          is_signed_nxt_s = 1'b0;
          part_nxt_s      = PART_FIRST;
          n1_nxt_s        = n1_s[1:0];
          // Second half: start of the next word, remaining bytes.
          sec_addr_nxt_s      = {req_addr_Q102H[31:2], 2'b00} + 32'd4;
          sec_wr_data_nxt_s   = req_wr_data_Q102H >> {n1_s[1:0], 3'b000};
          sec_wr_en_nxt_s     = req_is_store_Q102H;
          sec_byte_en_nxt_s   = len_mask(n2_s);
          sec_is_signed_nxt_s = req_is_signed_Q102H;
          state_nxt_s         = SECOND;
`else
          err_nxt_s = 1'b1;
`endif
        end else if (req_valid_Q102H) begin
          addr_nxt_s      = req_addr_Q102H;
          wr_data_nxt_s   = req_wr_data_Q102H;
          wr_en_nxt_s     = req_is_store_Q102H;
          byte_en_nxt_s   = len_mask(sz_s);
          is_signed_nxt_s = req_is_signed_Q102H;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
`ifdef RV_LSU_MISALIGN_EN
      SECOND: begin
        addr_nxt_s      = sec_addr_r;
        wr_data_nxt_s   = sec_wr_data_r;
        wr_en_nxt_s     = sec_wr_en_r;
        byte_en_nxt_s   = sec_byte_en_r;
        is_signed_nxt_s = sec_is_signed_r;
        part_nxt_s      = PART_SECOND;
        state_nxt_s     = IDLE;
      end
`endif
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and Q103H registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= 32'd0;
      wr_data_r   <= 32'd0;
      wr_en_r     <= 1'b0;
      byte_en_r   <= 4'b0000;
      is_signed_r <= 1'b0;
      part_r      <= PART_NONE;
      n1_r        <= 2'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      wr_en_r     <= wr_en_nxt_s;
      byte_en_r   <= byte_en_nxt_s;
      is_signed_r <= is_signed_nxt_s;
      part_r      <= part_nxt_s;
      n1_r        <= n1_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

`ifdef RV_LSU_MISALIGN_EN
  // Latched second half of a split access, replayed from the SECOND state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_addr_r      <= 32'd0;
      sec_wr_data_r   <= 32'd0;
      sec_wr_en_r     <= 1'b0;
      sec_byte_en_r   <= 4'b0000;
      sec_is_signed_r <= 1'b0;
    end else begin
      sec_addr_r      <= sec_addr_nxt_s;
      sec_wr_data_r   <= sec_wr_data_nxt_s;
      sec_wr_en_r     <= sec_wr_en_nxt_s;
      sec_byte_en_r   <= sec_byte_en_nxt_s;
      sec_is_signed_r <= sec_is_signed_nxt_s;
    end
  end

  assign stall_Q102H        = (state_r == SECOND);
  assign misalign_err_Q103H = 1'b0;
`else
  assign stall_Q102H        = 1'b0;
  assign misalign_err_Q103H = err_r;
`endif

  assign addr_Q103H      = addr_r;
  assign wr_data_Q103H   = wr_data_r;
  assign wr_en_Q103H     = wr_en_r;
  assign byte_en_Q103H   = byte_en_r;
  assign is_signed_Q103H = is_signed_r;

  rv_ld_merge u_ld_merge (
    .clk             (clk),
    .rst_n           (rst_n),
    .acc_valid_Q103H (|byte_en_r),
    .is_load_Q103H   (~wr_en_r),
    .part_Q103H      (part_r),
    .n1_Q103H        (n1_r),
    .rd_data_Q104H   (rd_data_Q104H),
    .ld_data_Q104H   (ld_data_Q104H),
    .ld_valid_Q104H  (ld_valid_Q104H)
  );

endmodule

// File: tb/tb_rv_lsu_split.sv
// tb_rv_lsu_split: directed vectors with a queued scoreboard for the
// Q103H access stream and the Q104H load results.
module tb_rv_lsu_split;

  logic        clk;
  logic        rst_n;
  logic        req_valid_Q102H;
  logic [31:0] req_addr_Q102H;
  logic [31:0] req_wr_data_Q102H;
  logic        req_is_store_Q102H;
  logic [1:0]  req_size_Q102H;
  logic        req_is_signed_Q102H;
  logic        stall_Q102H;
  logic [31:0] addr_Q103H;
  logic [31:0] wr_data_Q103H;
  logic        wr_en_Q103H;
  logic [3:0]  byte_en_Q103H;
  logic        is_signed_Q103H;
  logic [31:0] rd_data_Q104H;
  logic [31:0] ld_data_Q104H;
  logic        ld_valid_Q104H;
  logic        misalign_err_Q103H;

`ifdef RV_LSU_MISALIGN_EN
  localparam logic SPLIT = 1'b1;
`else
  localparam logic SPLIT = 1'b0;
`endif

  rv_lsu_split dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid_Q102H     (req_valid_Q102H),
    .req_addr_Q102H      (req_addr_Q102H),
    .req_wr_data_Q102H   (req_wr_data_Q102H),
    .req_is_store_Q102H  (req_is_store_Q102H),
    .req_size_Q102H      (req_size_Q102H),
    .req_is_signed_Q102H (req_is_signed_Q102H),
    .stall_Q102H         (stall_Q102H),
    .addr_Q103H          (addr_Q103H),
    .wr_data_Q103H       (wr_data_Q103H),
    .wr_en_Q103H         (wr_en_Q103H),
    .byte_en_Q103H       (byte_en_Q103H),
    .is_signed_Q103H     (is_signed_Q103H),
    .rd_data_Q104H       (rd_data_Q104H),
    .ld_data_Q104H       (ld_data_Q104H),
    .ld_valid_Q104H      (ld_valid_Q104H),
    .misalign_err_Q103H  (misalign_err_Q103H)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [3:0]  be;
    logic        sgn;
    logic        err;
  } q103_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } ld_t;

  q103_t       exp_q103[$];
  ld_t         exp_ld[$];
  logic [31:0] resp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ld_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_acc(input int c, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [3:0] be, input logic sg);
    q103_t e;
    e.cyc = c; e.addr = a; e.wdata = wd; e.wr_en = we; e.be = be; e.sgn = sg; e.err = 1'b0;
    exp_q103.push_back(e);
  endtask

  task automatic exp_err(input int c);
    q103_t e;
    e.cyc = c; e.addr = 32'd0; e.wdata = 32'd0; e.wr_en = 1'b0; e.be = 4'b0000; e.sgn = 1'b0; e.err = 1'b1;
    exp_q103.push_back(e);
  endtask

  task automatic exp_load(input int c, input logic [31:0] d);
    ld_t e;
    e.cyc = c; e.data = d;
    exp_ld.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic st,
                       input logic [1:0] sz, input logic sg);
    req_valid_Q102H     = 1'b1;
    req_addr_Q102H      = a;
    req_wr_data_Q102H   = wd;
    req_is_store_Q102H  = st;
    req_size_Q102H      = sz;
    req_is_signed_Q102H = sg;
    check("stall_at_issue", 128'(stall_Q102H), 128'(1'b0));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid_Q102H = 1'b0;
    @(posedge clk); #1;
  endtask

  // Wrapper model: a load seen on Q103H gets its queued read data next cycle.
  initial begin
    logic pend;
    rd_data_Q104H = 32'd0;
    forever begin
      @(negedge clk);
      pend = (byte_en_Q103H != 4'b0000) && !wr_en_Q103H;
      @(posedge clk); #1;
      if (pend && resp_q.size() > 0) rd_data_Q104H = resp_q.pop_front();
      else rd_data_Q104H = 32'd0;
    end
  end

  // Monitor: compare every presented access and load result against the queues.
  initial begin
    q103_t eq;
    ld_t   el;
    forever begin
      @(negedge clk);
      if (byte_en_Q103H != 4'b0000 || misalign_err_Q103H) begin
        if (exp_q103.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL q103_unexpected: got addr %0h be %b err %b, expected no access",
                   addr_Q103H, byte_en_Q103H, misalign_err_Q103H);
        end else begin
          eq = exp_q103.pop_front();
          check("q103_cycle", 128'(cyc), 128'(eq.cyc));
          if (eq.err)
            check("q103_err", 128'({misalign_err_Q103H, wr_en_Q103H, byte_en_Q103H}),
                  128'({1'b1, 1'b0, 4'b0000}));
          else
            check("q103_fields",
                  128'({addr_Q103H, wr_data_Q103H, wr_en_Q103H, byte_en_Q103H, is_signed_Q103H, misalign_err_Q103H}),
                  128'({eq.addr, eq.wdata, eq.wr_en, eq.be, eq.sgn, 1'b0}));
        end
      end
      if (ld_valid_Q104H) begin
        ld_cnt++;
        if (exp_ld.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL ld_unexpected: got data %0h, expected no load result", ld_data_Q104H);
        end else begin
          el = exp_ld.pop_front();
          check("ld_cycle", 128'(cyc), 128'(el.cyc));
          check("ld_data", 128'(ld_data_Q104H), 128'(el.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ld_before;
    rst_n = 1'b0;
    req_valid_Q102H = 1'b0;
    req_addr_Q102H = 32'd0;
    req_wr_data_Q102H = 32'd0;
    req_is_store_Q102H = 1'b0;
    req_size_Q102H = 2'd0;
    req_is_signed_Q102H = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q103", 128'({addr_Q103H, wr_data_Q103H, wr_en_Q103H, byte_en_Q103H, is_signed_Q103H}), 128'(0));
    check("reset_misc", 128'({stall_Q102H, misalign_err_Q103H, ld_valid_Q104H, ld_data_Q104H}), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word store to 8.
    n = cyc;
    exp_acc(n + 1, 32'd8, 32'hAABB_CCDD, 1'b1, 4'b1111, 1'b0);
    issue(32'd8, 32'hAABB_CCDD, 1'b1, 2'd2, 1'b0);
    check("stall_aligned", 128'(stall_Q102H), 128'(1'b0));
    idle(); idle();

    // Aligned signed byte load at 5.
    n = cyc;
    exp_acc(n + 1, 32'd5, 32'd0, 1'b0, 4'b0001, 1'b1);
    resp_q.push_back(32'hFFFF_FFCC);
    exp_load(n + 2, 32'hFFFF_FFCC);
    issue(32'd5, 32'd0, 1'b0, 2'd0, 1'b1);
    idle(); idle();

    // Back-to-back aligned accesses: half store, word load, signed half load.
    n = cyc;
    exp_acc(n + 1, 32'h10, 32'h5566, 1'b1, 4'b0011, 1'b0);
    exp_acc(n + 2, 32'h20, 32'd0, 1'b0, 4'b1111, 1'b0);
    exp_acc(n + 3, 32'h22, 32'd0, 1'b0, 4'b0011, 1'b1);
    resp_q.push_back(32'h89AB_CDEF);
    resp_q.push_back(32'hFFFF_8001);
    exp_load(n + 3, 32'h89AB_CDEF);
    exp_load(n + 4, 32'hFFFF_8001);
    issue(32'h10, 32'h5566, 1'b1, 2'd1, 1'b0);
    issue(32'h20, 32'd0, 1'b0, 2'd2, 1'b0);
    issue(32'h22, 32'd0, 1'b0, 2'd3 & 2'd1, 1'b1);
    idle(); idle(); idle();

    // Misaligned half store 0x1234 at 3.
    n = cyc;
`ifdef RV_LSU_MISALIGN_EN
    exp_acc(n + 1, 32'd3, 32'h1234, 1'b1, 4'b0001, 1'b0);
    exp_acc(n + 2, 32'd4, 32'h12, 1'b1, 4'b0001, 1'b0);
    exp_acc(n + 3, 32'h40, 32'h77, 1'b1, 4'b0001, 1'b0);
    issue(32'd3, 32'h1234, 1'b1, 2'd1, 1'b0);
    check("stall_split", 128'(stall_Q102H), 128'(1'b1));
    // Present the next request during the stall; it is taken only afterwards.
    req_valid_Q102H = 1'b1;
    req_addr_Q102H = 32'h40;
    req_wr_data_Q102H = 32'h77;
    req_is_store_Q102H = 1'b1;
    req_size_Q102H = 2'd0;
    req_is_signed_Q102H = 1'b0;
    @(posedge clk); #1;
    check("stall_release", 128'(stall_Q102H), 128'(1'b0));
    @(posedge clk); #1;
    req_valid_Q102H = 1'b0;
`else
    exp_err(n + 1);
    issue(32'd3, 32'h1234, 1'b1, 2'd1, 1'b0);
    check("stall_tied", 128'(stall_Q102H), 128'(1'b0));
`endif
    idle(); idle();

    // Misaligned word store at 1.
    n = cyc;
    if (SPLIT) begin
      exp_acc(n + 1, 32'd1, 32'h1122_3344, 1'b1, 4'b0111, 1'b0);
      exp_acc(n + 2, 32'd4, 32'h11, 1'b1, 4'b0001, 1'b0);
    end else begin
      exp_err(n + 1);
    end
    issue(32'd1, 32'h1122_3344, 1'b1, 2'd2, 1'b0);
    check("stall_word_store", 128'(stall_Q102H), 128'(SPLIT));
    idle(); idle();

    // Misaligned unsigned half load at 7.
    n = cyc;
    if (SPLIT) begin
      exp_acc(n + 1, 32'd7, 32'd0, 1'b0, 4'b0001, 1'b0);
      exp_acc(n + 2, 32'd8, 32'd0, 1'b0, 4'b0001, 1'b0);
      resp_q.push_back(32'h0000_00AB);
      resp_q.push_back(32'h0000_00CD);
      exp_load(n + 3, 32'h0000_CDAB);
    end else begin
      exp_err(n + 1);
    end
    issue(32'd7, 32'd0, 1'b0, 2'd1, 1'b0);
    idle(); idle(); idle();

    // Misaligned signed word load at 6.
    n = cyc;
    if (SPLIT) begin
      exp_acc(n + 1, 32'd6, 32'd0, 1'b0, 4'b0011, 1'b0);
      exp_acc(n + 2, 32'd8, 32'd0, 1'b0, 4'b0011, 1'b1);
      resp_q.push_back(32'h0000_BEEF);
      resp_q.push_back(32'hFFFF_DEAD);
      exp_load(n + 3, 32'hDEAD_BEEF);
    end else begin
      exp_err(n + 1);
    end
    issue(32'd6, 32'd0, 1'b0, 2'd2, 1'b1);
    idle(); idle(); idle();

    // Reset in cycle N+2 of a split load: everything is discarded.
    n = cyc;
    if (SPLIT) begin
      exp_acc(n + 1, 32'd6, 32'd0, 1'b0, 4'b0011, 1'b0);
      resp_q.push_back(32'h0000_BEEF);
      resp_q.push_back(32'hFFFF_DEAD);
    end else begin
      exp_err(n + 1);
    end
    issue(32'd6, 32'd0, 1'b0, 2'd2, 1'b1);
    idle();
    ld_before = ld_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_q103", 128'({addr_Q103H, wr_data_Q103H, wr_en_Q103H, byte_en_Q103H, is_signed_Q103H}), 128'(0));
    check("rst_mid_misc", 128'({stall_Q102H, misalign_err_Q103H, ld_valid_Q104H, ld_data_Q104H}), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_q.delete();
    idle(); idle(); idle();
    check("rst_no_ld", 128'(ld_cnt), 128'(ld_before));

    // Aligned word load after reset completes normally.
    n = cyc;
    exp_acc(n + 1, 32'h30, 32'd0, 1'b0, 4'b1111, 1'b0);
    resp_q.push_back(32'h1357_9BDF);
    exp_load(n + 2, 32'h1357_9BDF);
    issue(32'h30, 32'd0, 1'b0, 2'd2, 1'b0);
    idle(); idle(); idle();

    check("q103_drained", 128'(exp_q103.size()), 128'(0));
    check("ld_drained", 128'(exp_ld.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_lsu_split.md
# rv_lsu_split

Load/store issue stage between execute (Q102H) and the data-memory wrapper `rv_dmem_wrap` (Q103H/Q104H). It registers a memory request into the Q103H signals the wrapper consumes. A misaligned access, one that crosses a 4-byte word boundary, is split into two consecutive wrapper accesses while the pipeline is stalled. For loads, the two Q104H read returns are merged into one result.

## Interface
- No parameters.
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid_Q102H`  in  1  memory request present
- `req_addr_Q102H`  in  32  byte address
- `req_wr_data_Q102H`  in  32  store data, low-justified
- `req_is_store_Q102H`  in  1  1 = store, 0 = load
- `req_size_Q102H`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- `req_is_signed_Q102H`  in  1  sign-extend load result
- `stall_Q102H`  out  1  hold Q102H; the request is not accepted this cycle
- `addr_Q103H`  out  32  to wrapper
- `wr_data_Q103H`  out  32  to wrapper, low-justified
- `wr_en_Q103H`  out  1  to wrapper
- `byte_en_Q103H`  out  4  to wrapper; contiguous low-justified mask (0001, 0011, 0111, 1111) of bytes starting at `addr_Q103H`
- `is_signed_Q103H`  out  1  to wrapper
- `rd_data_Q104H`  in  32  from wrapper
- `ld_data_Q104H`  out  32  final load result
- `ld_valid_Q104H`  out  1  `ld_data_Q104H` is valid this cycle
- `misalign_err_Q103H`  out  1  misaligned request rejected (only when splitting is compiled out)

## Operation
- Definitions: `sz` = 1/2/4 bytes; `off` = `addr[1:0]`; the request is misaligned iff `off + sz > 4`.
- Misaligned split: `n1 = 4 - off` and `n2 = sz - n1`.
- FSM states: `IDLE` and `SECOND`.
- **IDLE, valid aligned request:**
  - Registers `addr`, `wr_data`, `wr_en = is_store`, `byte_en` = mask(`sz`), `is_signed`.
  - Next state: IDLE.
- **IDLE, valid misaligned request:**
  - First part: `addr`, `byte_en` = mask(`n1`), `wr_data` unchanged, `is_signed` = 0.
  - Latches the second part: `addr = (addr & ~3) + 4`, `byte_en` = mask(`n2`), `wr_data = wr_data >> 8*n1`, `is_signed` = request value.
  - Next state: SECOND.
- **SECOND:**
  - Drives the latched second part into Q103H.
  - `stall_Q102H` is 1 for the whole cycle; the Q102H request is ignored.
  - Next state: IDLE.
- **No valid request in IDLE:** `wr_en_Q103H` = 0 and `byte_en_Q103H` = 0. Address and data hold their last value.
- **Load tracking:** a Q104H tag register records `valid`, `is_load`, `part` (none / first / second) and `n1`.
- **Load merge:**
  - Aligned load: `ld_data_Q104H = rd_data_Q104H`.
  - First part: `rd_data_Q104H` is captured into a holding register; `ld_valid_Q104H` stays 0.
  - Second part: `ld_data_Q104H = (rd_data_Q104H << 8*n1) | hold`, with `ld_valid_Q104H` = 1. The wrapper's sign extension of the second part supplies the upper bits.
- Stores never assert `ld_valid_Q104H`.
- Reset values (all outputs 0): state = IDLE; Q103H outputs, tags, `hold`, `stall_Q102H` and `misalign_err_Q103H` all 0.

## Timing
- Request accepted at the clock edge ending the cycle N in which `req_valid_Q102H` = 1 and `stall_Q102H` = 0.
- Aligned access:
  - Q103H outputs valid in cycle N+1.
  - Load result in cycle N+2.
- Misaligned access:
  - Parts issued in cycles N+1 and N+2.
  - `stall_Q102H` high in N+1 only.
  - Load result (single `ld_valid_Q104H` pulse) in N+3.
- Back-to-back aligned requests run at one per cycle with no bubbles.
- `stall_Q102H` is a Moore output (state == SECOND); it has no combinational path from the Q102H inputs.
- Asynchronous reset mid-split:
  - FSM returns to IDLE and all outputs clear immediately.
  - Any pending second part and held load data are discarded; no `ld_valid_Q104H` is produced.

## Configuration
- `RV_LSU_MISALIGN_EN` defined: misaligned accesses are split as described; `misalign_err_Q103H` is tied to 0.
- `RV_LSU_MISALIGN_EN` undefined:
  - No SECOND state and `stall_Q102H` is tied to 0.
  - A misaligned request produces `wr_en_Q103H` = 0, `byte_en_Q103H` = 0 and a one-cycle `misalign_err_Q103H` pulse in N+1.
  - No `ld_valid_Q104H` for that request.

## Structure
- Package `rv_lsu_pkg`:
  - `t_mem_size` enum (BYTE, HALF, WORD)
  - `t_lsu_state` enum (IDLE, SECOND)
  - functions `size_bytes()` and `len_mask()` (n → 4-bit low-justified mask)
- Sub-module `rv_ld_merge`: Q104H tag register, holding register and merge logic. The top level contains the FSM and the Q103H registers.

## Test plan
- Aligned store, word `0xAABBCCDD` to addr 8 → N+1: `addr` = 8, `byte_en` = 1111, `wr_en` = 1; `stall_Q102H` never asserted.
- Aligned signed byte load at addr 5, wrapper returns `0xFFFFFFCC` → `ld_valid_Q104H` pulse in N+2 with `ld_data_Q104H` = `0xFFFFFFCC`.
- Misaligned half store `0x1234` to addr 3:
  - N+1: `addr` = 3, `byte_en` = 0001, `wr_data` = `0x1234`.
  - N+2: `addr` = 4, `byte_en` = 0001, `wr_data` = `0x12`.
  - `stall_Q102H` = 1 in N+1.
- Misaligned signed word load at addr 6:
  - Parts: (6, 0011, signed 0) then (8, 0011, signed 1).
  - Wrapper returns `0x0000BEEF` then `0xFFFFDEAD` → a single `ld_valid_Q104H` pulse in N+3 with `ld_data_Q104H` = `0xDEADBEEF`.
- Assert `rst_n` low during N+2 of a misaligned load → all outputs 0 immediately; no `ld_valid_Q104H` after release; the next aligned request completes normally.
- Without the macro: word store to addr 1 → `wr_en_Q103H` stays 0, one `misalign_err_Q103H` pulse, `stall_Q102H` = 0.
